// File: rtl/game_ctrl_param.sv
// Memory-game controller: the round/play FSM together with its round counter,
// user step index, key compare, play timeout and win detection.
module game_ctrl_param #(
  parameter int ROUND_W    = 4,
  parameter int MAX_ROUNDS = 16,
  parameter int SYM_W      = 4,
  parameter int TIME_LIMIT = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enter,
  input  logic               tick,
  input  logic [ROUND_W-1:0] max_rounds,
  input  logic               fpga_done,
  input  logic               key_valid,
  input  logic [SYM_W-1:0]   key_code,
  input  logic [SYM_W-1:0]   seq_data,
  output logic [ROUND_W-1:0] seq_addr,
  output logic [ROUND_W-1:0] fpga_len,
  output logic [ROUND_W-1:0] round_cnt,
  output logic [3:0]         time_cnt,
  output logic [2:0]         state_o,
  output logic               r1,
  output logic               r2,
  output logic               e1,
  output logic               e2,
  output logic               e3,
  output logic               e4,
  output logic               sel,
  output logic               win_o,
  output logic               timeout_o,
  output logic               miss_o
);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    SETUP      = 3'd1,
    PLAY_FPGA  = 3'd2,
    PLAY_USER  = 3'd3,
    CHECK      = 3'd4,
    NEXT_ROUND = 3'd5,
    RESULT     = 3'd6
  } state_t;

  localparam logic [3:0]         TL        = 4'(TIME_LIMIT);
  localparam logic [ROUND_W-1:0] MAX_R_CAP = ROUND_W'(MAX_ROUNDS);

  state_t             state, state_n;
  logic               enter_q, enter_rise;
  logic [ROUND_W-1:0] max_r, user_idx;
  logic               clr_game, latch_max, clr_play, time_inc, key_acc;
  logic               set_timeout, round_inc, set_win;

  // A request of 0 still plays one round; larger requests stop at the hard ceiling.
  function automatic logic [ROUND_W-1:0] clamp_rounds(input logic [ROUND_W-1:0] req);
    if (req == '0)
      return ROUND_W'(1);
    else if (int'(req) > MAX_ROUNDS)
      return MAX_R_CAP;
    else
      return req;
  endfunction

  function automatic logic [3:0] sat_inc_time(input logic [3:0] t);
    return (t >= TL) ? TL : t + 4'd1;
  endfunction

  assign enter_rise = enter & ~enter_q;

  always_ff @(posedge clock) begin
    if (reset) state <= INIT;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    clr_game    = 1'b0;
    latch_max   = 1'b0;
    clr_play    = 1'b0;
    time_inc    = 1'b0;
    key_acc     = 1'b0;
    set_timeout = 1'b0;
    round_inc   = 1'b0;
    set_win     = 1'b0;
    r1          = 1'b0;
    r2          = 1'b0;
    e1          = 1'b0;
    e2          = 1'b0;
    e3          = 1'b0;
    e4          = 1'b0;
    sel         = 1'b0;
    case (state)
      INIT: begin
        r1       = 1'b1;
        r2       = 1'b1;
        clr_game = 1'b1;
        state_n  = SETUP;
      end
      SETUP: begin
        e1 = 1'b1;
        if (enter_rise) begin
          latch_max = 1'b1;
          state_n   = PLAY_FPGA;
        end
      end
      PLAY_FPGA: begin
        e3 = 1'b1;
        if (fpga_done) begin
          clr_play = 1'b1;
          state_n  = PLAY_USER;
        end
      end
      PLAY_USER: begin
        e2 = 1'b1;
        // Expiry wins over a key arriving in the same cycle; that key is dropped.
        if (time_cnt == TL) begin
          set_timeout = 1'b1;
          state_n     = RESULT;
        end else begin
          time_inc = tick;
          key_acc  = key_valid;
          if (key_valid && (user_idx == round_cnt))
            state_n = CHECK;
        end
      end
      CHECK: begin
        e4 = 1'b1;
        if (miss_o) begin
          state_n = RESULT;
        end else begin
          round_inc = 1'b1;
          state_n   = NEXT_ROUND;
        end
      end
      NEXT_ROUND: begin
        r2 = 1'b1;
        if (round_cnt == max_r) begin
          set_win = 1'b1;
          state_n = RESULT;
        end else begin
          state_n = PLAY_FPGA;
        end
      end
      RESULT: begin
        sel = 1'b1;
        if (enter_rise)
          state_n = INIT;
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enter_q   <= 1'b0;
      max_r     <= '0;
      round_cnt <= '0;
      user_idx  <= '0;
      time_cnt  <= '0;
      win_o     <= 1'b0;
      timeout_o <= 1'b0;
      miss_o    <= 1'b0;
    end else begin
      enter_q <= enter;
      if (clr_game) begin
        round_cnt <= '0;
        user_idx  <= '0;
        time_cnt  <= '0;
        win_o     <= 1'b0;
        timeout_o <= 1'b0;
        miss_o    <= 1'b0;
      end
      if (latch_max)
        max_r <= clamp_rounds(max_rounds);
      if (clr_play) begin
        user_idx <= '0;
        time_cnt <= '0;
        miss_o   <= 1'b0;
      end
      if (time_inc)
        time_cnt <= sat_inc_time(time_cnt);
      if (key_acc) begin
        if (key_code != seq_data)
          miss_o <= 1'b1;
        user_idx <= user_idx + ROUND_W'(1);
      end
      if (set_timeout)
        timeout_o <= 1'b1;
      if (round_inc)
        round_cnt <= round_cnt + ROUND_W'(1);
      if (set_win)
        win_o <= 1'b1;
    end
  end

  assign state_o  = state;
  assign seq_addr = (state == PLAY_USER) ? user_idx : '0;
  assign fpga_len = round_cnt;

endmodule

// File: tb/tb_game_ctrl_param.sv
// Bench for game_ctrl_param: directed game scenarios plus randomized play, all
// checked every cycle against a game-rules model kept in the bench.
module tb_game_ctrl_param;

  localparam int RW   = 4;
  localparam int MAXR = 8;
  localparam int SW   = 4;
  localparam int TL   = 3;

  localparam int S_INIT = 0, S_SETUP = 1, S_FPGA = 2, S_USER = 3,
                 S_CHECK = 4, S_NEXT = 5, S_RESULT = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enter = 1'b0;
  logic          tick = 1'b0;
  logic          fpga_done = 1'b0;
  logic          key_valid = 1'b0;
  logic [RW-1:0] max_rounds = '0;
  logic [SW-1:0] key_code = '0;
  logic [SW-1:0] seq_data;
  logic [RW-1:0] seq_addr, fpga_len, round_cnt;
  logic [3:0]    time_cnt;
  logic [2:0]    state_o;
  logic          r1, r2, e1, e2, e3, e4, sel, win_o, timeout_o, miss_o;

  logic [SW-1:0] rom [16];
  assign seq_data = rom[seq_addr];

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  game_ctrl_param #(.ROUND_W(RW), .MAX_ROUNDS(MAXR), .SYM_W(SW), .TIME_LIMIT(TL)) dut (
    .clock(clock), .reset(reset), .enter(enter), .tick(tick), .max_rounds(max_rounds),
    .fpga_done(fpga_done), .key_valid(key_valid), .key_code(key_code), .seq_data(seq_data),
    .seq_addr(seq_addr), .fpga_len(fpga_len), .round_cnt(round_cnt), .time_cnt(time_cnt),
    .state_o(state_o), .r1(r1), .r2(r2), .e1(e1), .e2(e2), .e3(e3), .e4(e4), .sel(sel),
    .win_o(win_o), .timeout_o(timeout_o), .miss_o(miss_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int st;
    int round;
    int idx;
    int tcnt;
    int maxr;
    bit win;
    bit to;
    bit miss;
    bit eprev;
  } mstate_t;

  mstate_t m = '0;

  // Game rules applied once per clock edge to the current inputs.
  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n;
    bit rise;
    int mr;
    n = s;
    if (reset) begin
      n = '0;
      n.st = S_INIT;
      return n;
    end
    rise = enter && !s.eprev;
    n.eprev = enter;
    case (s.st)
      S_INIT: begin
        n.round = 0; n.idx = 0; n.tcnt = 0;
        n.win = 0; n.to = 0; n.miss = 0;
        n.st = S_SETUP;
      end
      S_SETUP: if (rise) begin
        mr = int'(max_rounds);
        n.maxr = (mr == 0) ? 1 : ((mr > MAXR) ? MAXR : mr);
        n.st = S_FPGA;
      end
      S_FPGA: if (fpga_done) begin
        n.idx = 0; n.tcnt = 0; n.miss = 0;
        n.st = S_USER;
      end
      S_USER: begin
        if (s.tcnt == TL) begin
          n.to = 1;
          n.st = S_RESULT;
        end else begin
          if (tick && s.tcnt < TL) n.tcnt = s.tcnt + 1;
          if (key_valid) begin
            if (key_code != rom[s.idx % 16]) n.miss = 1;
            n.idx = s.idx + 1;
            if (s.idx == s.round) n.st = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (s.miss) n.st = S_RESULT;
        else begin
          n.round = s.round + 1;
          n.st = S_NEXT;
        end
      end
      S_NEXT: begin
        if (s.round == s.maxr) begin
          n.win = 1;
          n.st = S_RESULT;
        end else n.st = S_FPGA;
      end
      S_RESULT: if (rise) n.st = S_INIT;
      default: n.st = S_INIT;
    endcase
    return n;
  endfunction

  function automatic logic [6:0] strobes(input int st);
    case (st)
      S_INIT:   return 7'b1100000;
      S_SETUP:  return 7'b0010000;
      S_FPGA:   return 7'b0000100;
      S_USER:   return 7'b0001000;
      S_CHECK:  return 7'b0000010;
      S_NEXT:   return 7'b0100000;
      S_RESULT: return 7'b0000001;
      default:  return 7'b0000000;
    endcase
  endfunction

  always @(posedge clock) m <= model_next(m);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("state", 32'(state_o), m.st);
      chk("round_cnt", 32'(round_cnt), m.round);
      chk("fpga_len", 32'(fpga_len), m.round);
      chk("time_cnt", 32'(time_cnt), m.tcnt);
      chk("seq_addr", 32'(seq_addr), (m.st == S_USER) ? m.idx : 0);
      chk("win_o", 32'(win_o), 32'(m.win));
      chk("timeout_o", 32'(timeout_o), 32'(m.to));
      chk("miss_o", 32'(miss_o), 32'(m.miss));
      chk("strobes", 32'({r1, r2, e1, e2, e3, e4, sel}), 32'(strobes(m.st)));
    end
  end

  task automatic cyc(input bit en, input bit tk, input bit fd, input bit kv,
                     input logic [SW-1:0] kc);
    enter = en; tick = tk; fpga_done = fd; key_valid = kv; key_code = kc;
    @(negedge clock);
  endtask

  task automatic idle();
    cyc(enter, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic new_game(input logic [RW-1:0] mr);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    max_rounds = mr;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic play_round(input int r);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k <= r; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1, rom[k]);
    idle();
    idle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = SW'($urandom_range(0, 15));
    rom[0] = 4'h5;

    @(negedge clock);
    cmp_en = 1'b1;
    idle(); idle();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_strobes", 32'({r1, r2, e1, e2, e3, e4, sel}), 32'h60);
    chk("rst_round", 32'(round_cnt), 0);
    chk("rst_flags", 32'({win_o, timeout_o, miss_o}), 0);

    // Basic start and a full two-round win.
    reset = 1'b0;
    idle();
    chk("setup_state", 32'(state_o), S_SETUP);
    max_rounds = 4'd2;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("start_state", 32'(state_o), S_FPGA);
    chk("start_e3", 32'(e3), 1);
    chk("start_len", 32'(fpga_len), 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
    chk("user_state", 32'(state_o), S_USER);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, rom[0]);
    chk("check_state", 32'(state_o), S_CHECK);
    idle();
    chk("next_state", 32'(state_o), S_NEXT);
    chk("next_round", 32'(round_cnt), 1);
    idle();
    chk("back_fpga", 32'(state_o), S_FPGA);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, rom[0]);
    chk("idx1_addr", 32'(seq_addr), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, rom[1]);
    idle(); idle();
    chk("win_state", 32'(state_o), S_RESULT);
    chk("win_round", 32'(round_cnt), 2);
    chk("win_flag", 32'(win_o), 1);
    chk("win_sel", 32'(sel), 1);
    chk("model_win_round", 32'(m.round), 2);

    // RESULT holds while enter stays high; needs a fresh rising edge.
    repeat (3) idle();
    chk("result_hold", 32'(state_o), S_RESULT);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("result_exit", 32'(state_o), S_INIT);
    idle(); idle();
    chk("held_enter_setup", 32'(state_o), S_SETUP);

    // Wrong key on round 0.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h3);
    chk("miss_check", 32'(state_o), S_CHECK);
    chk("miss_flag", 32'(miss_o), 1);
    idle();
    chk("miss_result", 32'(state_o), S_RESULT);
    chk("miss_round", 32'(round_cnt), 0);
    chk("miss_nowin", 32'(win_o), 0);

    // Timeout after three ticks; the coinciding correct key is dropped.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("to_time", 32'(time_cnt), 3);
    chk("to_still_user", 32'(state_o), S_USER);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, rom[0]);
    chk("to_result", 32'(state_o), S_RESULT);
    chk("to_flag", 32'(timeout_o), 1);
    chk("to_nomiss", 32'(miss_o), 0);
    chk("model_to", 32'(m.to), 1);

    // max_rounds=0 plays exactly one round.
    new_game(4'd0);
    play_round(0);
    chk("mr0_state", 32'(state_o), S_RESULT);
    chk("mr0_round", 32'(round_cnt), 1);
    chk("mr0_win", 32'(win_o), 1);

    // max_rounds=15 is capped at 8.
    new_game(4'd15);
    for (int r = 0; r < MAXR; r++) play_round(r);
    chk("cap_state", 32'(state_o), S_RESULT);
    chk("cap_round", 32'(round_cnt), MAXR);
    chk("cap_win", 32'(win_o), 1);

    // Reset in the middle of PLAY_USER with pulses pending.
    new_game(4'd15);
    play_round(0);
    play_round(1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, rom[0]);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, rom[1]);
    chk("mid_addr", 32'(seq_addr), 2);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, rom[2]);
    chk("mid_rst_state", 32'(state_o), S_INIT);
    chk("mid_rst_round", 32'(round_cnt), 0);
    chk("mid_rst_time", 32'(time_cnt), 0);
    chk("mid_rst_addr", 32'(seq_addr), 0);
    reset = 1'b0;

    // Randomized play.
    for (int i = 0; i < 16; i++) rom[i] = SW'($urandom_range(0, 15));
    for (int c = 0; c < 20000; c++) begin
      bit en, tk, fd, kv;
      logic [SW-1:0] kc;
      int pick;
      reset = ($urandom_range(0, 999) == 0);
      en = ($urandom_range(0, 5) == 0) ? ~enter : enter;
      tk = ($urandom_range(0, 15) == 0);
      fd = ($urandom_range(0, 3) == 0);
      kv = ($urandom_range(0, 1) == 0);
      kc = ($urandom_range(0, 31) == 0) ? SW'($urandom_range(0, 15)) : rom[m.idx % 16];
      pick = $urandom_range(0, 3);
      max_rounds = (pick == 0) ? 4'd0 : (pick == 1) ? 4'd15 : RW'($urandom_range(0, 15));
      cyc(en, tk, fd, kv, kc);
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
